// File: rtl/z80_ld_ir_sequencer.sv
// Z80 register-transfer load sequencer: LD r,r' and LD A,I / I,A / A,R / R,A.
// Owns I, R and PC; emits one retirement record per completed instruction.
module z80_ld_ir_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int unsigned ED_EXTRA = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        byte_valid,
  output logic        byte_ready,
  input  logic [7:0]  byte_data,
  input  logic        iff2,
  output logic [2:0]  reg_rnum,
  input  logic [7:0]  reg_rdata,
  output logic        reg_wr,
  output logic [2:0]  reg_wnum,
  output logic [7:0]  reg_wdata,
  input  logic [7:0]  f_rdata,
  output logic        f_wr,
  output logic [7:0]  f_wdata,
  output logic [7:0]  i_q,
  output logic [7:0]  r_q,
  output logic [15:0] pc_q,
  output logic        retire_valid,
  input  logic        retire_ready,
  output logic [15:0] retire_insn,
  output logic [1:0]  retire_len,
  output logic [15:0] retire_pc,
  output logic        illegal
);

  typedef enum logic [2:0] {
    S_FETCH, S_FETCH2, S_EXEC, S_WB, S_RETIRE
  } state_t;

  localparam logic [2:0] ED_CNT = 3'(ED_EXTRA);

  state_t      state_q, state_d;
  logic [15:0] pc_d, rpc_q, rpc_d;
  logic [7:0]  r_d, i_d, op_q, op_d, lat_q, lat_d;
  logic        ed_q, ed_d, ill_q, ill_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  r_inc;
  logic        rr_ok, ed_ok;
  logic        is_ai, is_ar, is_ia;
  logic        unused_f;

  // Refresh counter: only the low 7 bits count, bit 7 is software-owned
  assign r_inc = {r_q[7], r_q[6:0] + 7'd1};

  assign rr_ok = (byte_data[7:6] == 2'b01)
              && (byte_data[5:3] != 3'b110)
              && (byte_data[2:0] != 3'b110);
  assign ed_ok = (byte_data == 8'h47) || (byte_data == 8'h4F)
              || (byte_data == 8'h57) || (byte_data == 8'h5F);

  assign is_ai = (op_q == 8'h57);
  assign is_ar = (op_q == 8'h5F);
  assign is_ia = (op_q == 8'h47);
  assign unused_f = ^f_rdata[7:1];

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    rpc_d      = rpc_q;
    r_d        = r_q;
    i_d        = i_q;
    op_d       = op_q;
    lat_d      = lat_q;
    ed_d       = ed_q;
    cnt_d      = cnt_q;
    ill_d      = 1'b0;
    byte_ready = 1'b0;
    reg_rnum   = 3'd0;
    reg_wr     = 1'b0;
    reg_wnum   = 3'd0;
    reg_wdata  = 8'h00;
    f_wr       = 1'b0;
    f_wdata    = 8'h00;
    unique case (state_q)
      S_FETCH: begin
        byte_ready = 1'b1;
        if (byte_valid) begin
          r_d   = r_inc;
          pc_d  = pc_q + 16'd1;
          rpc_d = pc_q;
          if (byte_data == 8'hED) begin
            ed_d    = 1'b1;
            state_d = S_FETCH2;
          end else if (rr_ok) begin
            ed_d    = 1'b0;
            op_d    = byte_data;
            cnt_d   = 3'd0;
            state_d = S_EXEC;
          end else begin
            ill_d = 1'b1;
          end
        end
      end
      S_FETCH2: begin
        byte_ready = 1'b1;
        if (byte_valid) begin
          r_d  = r_inc;
          pc_d = pc_q + 16'd1;
          if (ed_ok) begin
            op_d    = byte_data;
            cnt_d   = ED_CNT;
            state_d = S_EXEC;
          end else begin
            ill_d   = 1'b1;
            state_d = S_FETCH;
          end
        end
      end
      S_EXEC: begin
        if (!ed_q) begin
          reg_rnum = op_q[2:0];
          lat_d    = reg_rdata;
        end else if (is_ai) begin
          lat_d = i_q;
        end else if (is_ar) begin
          lat_d = r_q;
        end else begin
          reg_rnum = 3'b111;
          lat_d    = reg_rdata;
        end
        if (cnt_q == 3'd0) state_d = S_WB;
        else cnt_d = cnt_q - 3'd1;
      end
      S_WB: begin
        state_d = S_RETIRE;
        if (!ed_q) begin
          reg_wr    = 1'b1;
          reg_wnum  = op_q[5:3];
          reg_wdata = lat_q;
        end else if (is_ai || is_ar) begin
          reg_wr    = 1'b1;
          reg_wnum  = 3'b111;
          reg_wdata = lat_q;
          f_wr      = 1'b1;
          f_wdata   = {lat_q[7], lat_q == 8'h00, lat_q[5], 1'b0,
                       lat_q[3], iff2, 1'b0, f_rdata[0]};
        end else if (is_ia) begin
          i_d = lat_q;
        end else begin
          r_d = lat_q;
        end
      end
      S_RETIRE: begin
        if (retire_ready) state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      rpc_q   <= 16'h0000;
      r_q     <= 8'h00;
      i_q     <= 8'h00;
      op_q    <= 8'h00;
      lat_q   <= 8'h00;
      ed_q    <= 1'b0;
      cnt_q   <= 3'd0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      rpc_q   <= rpc_d;
      r_q     <= r_d;
      i_q     <= i_d;
      op_q    <= op_d;
      lat_q   <= lat_d;
      ed_q    <= ed_d;
      cnt_q   <= cnt_d;
      ill_q   <= ill_d;
    end
  end

  assign illegal      = ill_q;
  assign retire_valid = (state_q == S_RETIRE);
  assign retire_insn  = retire_valid ? {ed_q ? 8'hED : 8'h00, op_q} : 16'h0000;
  assign retire_len   = retire_valid ? (ed_q ? 2'd2 : 2'd1) : 2'd0;
  assign retire_pc    = retire_valid ? rpc_q : 16'h0000;

endmodule

// File: tb/tb_z80_ld_ir_sequencer.sv
// Directed bench for z80_ld_ir_sequencer with a simple register-file model.
// Each scenario task drives its stimulus and checks its own expectations.
module tb_z80_ld_ir_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic [7:0]  byte_data = 8'h00;
  logic        iff2 = 1'b0;
  logic [2:0]  reg_rnum;
  logic [7:0]  reg_rdata;
  logic        reg_wr;
  logic [2:0]  reg_wnum;
  logic [7:0]  reg_wdata;
  logic [7:0]  f_rdata = 8'h00;
  logic        f_wr;
  logic [7:0]  f_wdata;
  logic [7:0]  i_q, r_q;
  logic [15:0] pc_q;
  logic        retire_valid;
  logic        retire_ready = 1'b1;
  logic [15:0] retire_insn;
  logic [1:0]  retire_len;
  logic [15:0] retire_pc;
  logic        illegal;

  logic [7:0]  regs [8];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          acc = 0;

  int          n_wr, n_fwr, n_ill, n_ret, n_ovl;
  logic [2:0]  wnum_s;
  logic [7:0]  wdata_s, fdata_s;
  logic        rv_seen;
  int          rv_cyc;
  logic [15:0] rins_s, rpc_s;
  logic [1:0]  rlen_s;

  assign reg_rdata = regs[reg_rnum];

  z80_ld_ir_sequencer #(.RESET_PC(16'h0100), .ED_EXTRA(1)) dut (
    .clk(clk), .reset_n(reset_n),
    .byte_valid(byte_valid), .byte_ready(byte_ready),
    .byte_data(byte_data), .iff2(iff2),
    .reg_rnum(reg_rnum), .reg_rdata(reg_rdata),
    .reg_wr(reg_wr), .reg_wnum(reg_wnum), .reg_wdata(reg_wdata),
    .f_rdata(f_rdata), .f_wr(f_wr), .f_wdata(f_wdata),
    .i_q(i_q), .r_q(r_q), .pc_q(pc_q),
    .retire_valid(retire_valid), .retire_ready(retire_ready),
    .retire_insn(retire_insn), .retire_len(retire_len),
    .retire_pc(retire_pc), .illegal(illegal)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reg_wr) begin n_wr++; wnum_s = reg_wnum; wdata_s = reg_wdata; end
    if (f_wr) begin n_fwr++; fdata_s = f_wdata; end
    if (illegal) n_ill++;
    if (retire_valid && (reg_wr || f_wr || illegal)) n_ovl++;
    if (retire_valid && !rv_seen) begin
      rv_seen = 1'b1; rv_cyc = cyc; n_ret++;
      rins_s = retire_insn; rlen_s = retire_len; rpc_s = retire_pc;
    end
  end

  task automatic clear_mon();
    n_wr = 0; n_fwr = 0; n_ill = 0; n_ret = 0; n_ovl = 0;
    rv_seen = 1'b0; rv_cyc = 0;
    wnum_s = 3'd0; wdata_s = 8'h00; fdata_s = 8'h00;
    rins_s = 16'h0; rpc_s = 16'h0; rlen_s = 2'd0;
  endtask

  task automatic send(input logic [7:0] b, input bit first);
    bit ok = 1'b0;
    byte_data = b; byte_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (byte_ready) begin ok = 1'b1; break; end
    end
    if (first) acc = cyc;
    if (!ok) begin
      n_cmp++; n_fail++;
      $display("FAIL send_timeout byte=%h byte_ready stayed 0", b);
    end
    @(posedge clk); #1;
    byte_valid = 1'b0;
  endtask

  task automatic wait_retire();
    for (int k = 0; k < 40 && !rv_seen; k++) @(negedge clk);
    if (!rv_seen) begin
      n_cmp++; n_fail++;
      $display("FAIL retire_timeout retire_valid never seen, need 1");
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle(2);
    @(negedge clk);
    n_cmp++;
    if (pc_q !== 16'h0100 || r_q !== 8'h00 || i_q !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_regs pc=%h r=%h i=%h need 0100/00/00", pc_q, r_q, i_q);
    end
    n_cmp++;
    if ({retire_valid, reg_wr, f_wr, illegal} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_strobes got %b need 0000",
               {retire_valid, reg_wr, f_wr, illegal});
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    idle(1);
  endtask

  task automatic test_ld_rr();
    regs[7] = 8'h5A;
    clear_mon();
    send(8'h47, 1'b1);
    wait_retire();
    n_cmp++;
    if (n_wr !== 1 || wnum_s !== 3'd0 || wdata_s !== 8'h5A || n_fwr !== 0) begin
      n_fail++;
      $display("FAIL ldba_wb wr=%0d wnum=%0d wdata=%h fwr=%0d need 1/0/5A/0",
               n_wr, wnum_s, wdata_s, n_fwr);
    end
    n_cmp++;
    if (rins_s !== 16'h0047 || rlen_s !== 2'd1 || rpc_s !== 16'h0100) begin
      n_fail++;
      $display("FAIL ldba_retire insn=%h len=%0d pc=%h need 0047/1/0100",
               rins_s, rlen_s, rpc_s);
    end
    n_cmp++;
    if (rv_cyc - acc !== 3) begin
      n_fail++;
      $display("FAIL ldba_latency got %0d need 3", rv_cyc - acc);
    end
    n_cmp++;
    if (pc_q !== 16'h0101 || r_q !== 8'h01) begin
      n_fail++;
      $display("FAIL ldba_pc_r pc=%h r=%h need 0101/01", pc_q, r_q);
    end
    regs[1] = 8'h3C;
    clear_mon();
    send(8'h51, 1'b1);
    wait_retire();
    n_cmp++;
    if (wnum_s !== 3'd2 || wdata_s !== 8'h3C || rins_s !== 16'h0051) begin
      n_fail++;
      $display("FAIL lddc wnum=%0d wdata=%h insn=%h need 2/3C/0051",
               wnum_s, wdata_s, rins_s);
    end
  endtask

  task automatic test_ld_a_i();
    regs[7] = 8'hAA;
    iff2 = 1'b1; f_rdata = 8'h01;
    clear_mon();
    send(8'hED, 1'b1);
    send(8'h57, 1'b0);
    wait_retire();
    n_cmp++;
    if (n_wr !== 1 || wnum_s !== 3'd7 || wdata_s !== 8'h00) begin
      n_fail++;
      $display("FAIL ldai_wb wr=%0d wnum=%0d wdata=%h need 1/7/00",
               n_wr, wnum_s, wdata_s);
    end
    n_cmp++;
    if (n_fwr !== 1 || fdata_s !== 8'h45) begin
      n_fail++;
      $display("FAIL ldai_flags fwr=%0d f=%h need 1/45", n_fwr, fdata_s);
    end
    n_cmp++;
    if (rv_cyc - acc !== 5 || rins_s !== 16'hED57 || rlen_s !== 2'd2) begin
      n_fail++;
      $display("FAIL ldai_retire lat=%0d insn=%h len=%0d need 5/ED57/2",
               rv_cyc - acc, rins_s, rlen_s);
    end
    n_cmp++;
    if (r_q !== 8'h04 || pc_q !== 16'h0104) begin
      n_fail++;
      $display("FAIL ldai_pc_r pc=%h r=%h need 0104/04", pc_q, r_q);
    end
  endtask

  task automatic test_ld_i_a();
    regs[7] = 8'h80;
    clear_mon();
    send(8'hED, 1'b1);
    send(8'h47, 1'b0);
    wait_retire();
    n_cmp++;
    if (i_q !== 8'h80 || n_fwr !== 0 || n_wr !== 0) begin
      n_fail++;
      $display("FAIL ldia i=%h fwr=%0d wr=%0d need 80/0/0", i_q, n_fwr, n_wr);
    end
    n_cmp++;
    if (rins_s !== 16'hED47 || rlen_s !== 2'd2 || rpc_s !== 16'h0104
        || r_q !== 8'h06) begin
      n_fail++;
      $display("FAIL ldia_retire insn=%h len=%0d pc=%h r=%h need ED47/2/0104/06",
               rins_s, rlen_s, rpc_s, r_q);
    end
  endtask

  task automatic test_ld_r_a();
    regs[7] = 8'hFF;
    clear_mon();
    send(8'hED, 1'b1);
    send(8'h4F, 1'b0);
    wait_retire();
    n_cmp++;
    if (r_q !== 8'hFF || rins_s !== 16'hED4F) begin
      n_fail++;
      $display("FAIL ldra r=%h insn=%h need FF/ED4F", r_q, rins_s);
    end
    iff2 = 1'b0; f_rdata = 8'hFE;
    clear_mon();
    send(8'hED, 1'b1);
    send(8'h5F, 1'b0);
    wait_retire();
    n_cmp++;
    if (r_q !== 8'h81 || wdata_s !== 8'h81 || wnum_s !== 3'd7) begin
      n_fail++;
      $display("FAIL ldar r=%h wdata=%h wnum=%0d need 81/81/7",
               r_q, wdata_s, wnum_s);
    end
    n_cmp++;
    if (fdata_s !== 8'h80) begin
      n_fail++;
      $display("FAIL ldar_flags f=%h need 80", fdata_s);
    end
  endtask

  task automatic test_illegal();
    logic [15:0] pc0;
    logic [7:0] ops [3];
    ops[0] = 8'h76; ops[1] = 8'h46; ops[2] = 8'h00;
    for (int t = 0; t < 3; t++) begin
      pc0 = pc_q;
      clear_mon();
      if (t == 2) begin
        send(8'hED, 1'b1);
        send(ops[t], 1'b0);
      end else begin
        send(ops[t], 1'b1);
      end
      idle(6);
      n_cmp++;
      if (n_ill !== 1 || n_wr !== 0 || n_ret !== 0
          || pc_q !== pc0 + ((t == 2) ? 16'd2 : 16'd1)) begin
        n_fail++;
        $display("FAIL illegal_%0d ill=%0d wr=%0d ret=%0d dpc=%0d",
                 t, n_ill, n_wr, n_ret, pc_q - pc0);
      end
    end
  endtask

  task automatic test_stall();
    int bad = 0;
    logic [15:0] ins0, pc0;
    regs[0] = 8'h11;
    retire_ready = 1'b0;
    clear_mon();
    send(8'h78, 1'b1);
    for (int k = 0; k < 40 && !rv_seen; k++) @(negedge clk);
    ins0 = retire_insn; pc0 = retire_pc;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (!retire_valid || retire_insn !== ins0 || retire_pc !== pc0
          || retire_len !== 2'd1 || byte_ready !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad !== 0 || ins0 !== 16'h0078 || n_ovl !== 0) begin
      n_fail++;
      $display("FAIL stall bad=%0d insn=%h ovl=%0d need 0/0078/0",
               bad, ins0, n_ovl);
    end
    @(posedge clk); #1;
    retire_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (retire_valid !== 1'b0 || byte_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_release rv=%b br=%b need 0/1",
               retire_valid, byte_ready);
    end
    #1;
  endtask

  task automatic test_reset_exec();
    clear_mon();
    send(8'hED, 1'b1);
    send(8'h57, 1'b0);
    reset_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (pc_q !== 16'h0100 || r_q !== 8'h00 || i_q !== 8'h00
        || retire_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_exec pc=%h r=%h i=%h rv=%b need 0100/00/00/0",
               pc_q, r_q, i_q, retire_valid);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    idle(8);
    n_cmp++;
    if (n_ret !== 0 || n_wr !== 0 || n_fwr !== 0) begin
      n_fail++;
      $display("FAIL rst_exec_drop ret=%0d wr=%0d fwr=%0d need 0/0/0",
               n_ret, n_wr, n_fwr);
    end
  endtask

  initial begin
    for (int k = 0; k < 8; k++) regs[k] = 8'h00;
    clear_mon();
    test_reset();
    test_ld_rr();
    test_ld_a_i();
    test_ld_i_a();
    test_ld_r_a();
    test_illegal();
    test_stall();
    test_reset_exec();
    n_cmp++;
    if (n_ovl !== 0) begin
      n_fail++;
      $display("FAIL strobe_overlap count=%0d need 0", n_ovl);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
